// File: rtl/shift_defs_pkg.sv
// Shared definitions for the shift execute stage: R-type funct codes,
// FSM state encoding and the funct decoder.
package shift_defs;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ROT  = 1'b1
  } state_t;

  typedef struct packed {
    logic legal;
    logic rev;
    logic arith;
    logic var_amt;
    logic is_srl;
  } dec_t;

  function automatic dec_t decode_funct(input logic [5:0] f);
    dec_t d;
    d = '0;
    case (f)
      FN_SLL:  begin d.legal = 1'b1; d.rev = 1'b1; end
      FN_SRL:  begin d.legal = 1'b1; d.is_srl = 1'b1; end
      FN_SRA:  begin d.legal = 1'b1; d.arith = 1'b1; end
      FN_SLLV: begin d.legal = 1'b1; d.rev = 1'b1; d.var_amt = 1'b1; end
      FN_SRLV: begin d.legal = 1'b1; d.var_amt = 1'b1; d.is_srl = 1'b1; end
      FN_SRAV: begin d.legal = 1'b1; d.arith = 1'b1; d.var_amt = 1'b1; end
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/shifter.sv
// Combinational 32-bit right shifter; left shifts are done by bit-reversing
// the operand before and after the right shift (rev = 1).
module shifter (
  output logic [31:0] out,
  input  logic [31:0] in,
  input  logic        rev,
  input  logic        arithmetic,
  input  logic [4:0]  amt
);

  logic [31:0] w_pre;
  logic [31:0] w_post;

  function automatic logic [31:0] bit_rev(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

  always_comb begin
    w_pre  = rev ? bit_rev(in) : in;
    w_post = arithmetic ? 32'($signed(w_pre) >>> amt) : (w_pre >> amt);
    out    = rev ? bit_rev(w_post) : w_post;
  end

endmodule

// File: rtl/shift_exec_stage.sv
// Execute-stage wrapper around the shifter with a registered output slot.
// Define SHIFT_ROTATE_EN to add two-pass rotr/rotrv through the ROT state.
module shift_exec_stage
  import shift_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  funct,
  input  logic        rot,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic [4:0]  rd_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        illegal
);

  // Handshake: a side transfers on the edge where its valid and ready are both high.
  dec_t        w_dec;
  logic [4:0]  w_amt;
  logic [31:0] w_sh_in;
  logic [31:0] w_sh_out;
  logic        w_sh_rev;
  logic        w_sh_arith;
  logic [4:0]  w_sh_amt;
  logic        w_out_free;
  logic        w_accept;
  logic        w_is_rot;
  logic        w_rot_write;
  logic [31:0] w_rot_result;
  logic [4:0]  w_rot_rd;
  logic [26:0] w_unused_rs;

  logic        r_out_valid;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic        r_illegal;

  assign w_dec       = decode_funct(funct);
  assign w_amt       = w_dec.var_amt ? rs_val[4:0] : shamt;
  assign w_out_free  = !r_out_valid || out_ready;
  assign w_accept    = in_valid && in_ready;
  assign w_unused_rs = rs_val[31:5];

`ifdef SHIFT_ROTATE_EN
  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_rot_val;
  logic [31:0] r_partial;
  logic [4:0]  r_rot_n;
  logic [4:0]  r_rot_rd;

  assign w_is_rot     = w_dec.is_srl && rot;
  assign in_ready     = (r_state == ST_IDLE) && w_out_free;
  assign w_rot_write  = (r_state == ST_ROT) && w_out_free;
  assign w_rot_result = r_partial | w_sh_out;
  assign w_rot_rd     = r_rot_rd;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept && w_is_rot) w_next_state = ST_ROT;
      ST_ROT:  if (w_out_free) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // First pass (srl) is taken in IDLE; the partial holds it for the ROT pass.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_rot) begin
      r_rot_val <= rt_val;
      r_rot_n   <= w_amt;
      r_rot_rd  <= rd_in;
      r_partial <= w_sh_out;
    end
  end

  always_comb begin
    w_sh_in    = rt_val;
    w_sh_rev   = w_dec.rev;
    w_sh_arith = w_dec.arith;
    w_sh_amt   = w_amt;
    if (r_state == ST_ROT) begin
      w_sh_in    = r_rot_val;
      w_sh_rev   = 1'b1;
      w_sh_arith = 1'b0;
      w_sh_amt   = 5'd0 - r_rot_n;
    end
  end
`else
  logic [1:0] w_unused_rot;

  assign w_unused_rot = {rot, w_dec.is_srl};
  assign w_is_rot     = 1'b0;
  assign in_ready     = w_out_free;
  assign w_rot_write  = 1'b0;
  assign w_rot_result = '0;
  assign w_rot_rd     = '0;

  always_comb begin
    w_sh_in    = rt_val;
    w_sh_rev   = w_dec.rev;
    w_sh_arith = w_dec.arith;
    w_sh_amt   = w_amt;
  end
`endif

  shifter u_shifter (
    .out        (w_sh_out),
    .in         (w_sh_in),
    .rev        (w_sh_rev),
    .arithmetic (w_sh_arith),
    .amt        (w_sh_amt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rd        <= '0;
      r_illegal   <= 1'b0;
    end else if (w_rot_write) begin
      r_out_valid <= 1'b1;
      r_result    <= w_rot_result;
      r_rd        <= w_rot_rd;
      r_illegal   <= 1'b0;
    end else if (w_accept && !w_is_rot) begin
      r_out_valid <= 1'b1;
      r_result    <= w_dec.legal ? w_sh_out : '0;
      r_rd        <= rd_in;
      r_illegal   <= !w_dec.legal;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign rd_out    = r_rd;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed cases plus random
// traffic scored against a transaction-level reference model.
module tb_shift_exec_stage;

`ifdef SHIFT_ROTATE_EN
  localparam bit ROT_EN = 1'b1;
`else
  localparam bit ROT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  funct = '0;
  logic        rot = 1'b0;
  logic [4:0]  shamt = '0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic [4:0]  rd_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        illegal;

  int n_cmp = 0;
  int n_err = 0;

  // {illegal, rd, result}
  logic [37:0] exp_q[$];
  logic        m_ov;
  logic        m_rot;

  always #5 clk = ~clk;

  shift_exec_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .rot(rot), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val),
    .rd_in(rd_in), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .rd_out(rd_out), .illegal(illegal)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic is_rot_op(input logic [5:0] f, input logic r);
    return ROT_EN && r && (f == 6'b000010 || f == 6'b000110);
  endfunction

  // Returns {illegal, result} straight from the instruction semantics.
  function automatic logic [32:0] ref_op(input logic [5:0] f, input logic r,
                                         input logic [4:0] sa, input logic [31:0] rs,
                                         input logic [31:0] rt);
    logic [63:0] dbl;
    logic [4:0]  n;
    n   = (f == 6'b000100 || f == 6'b000110 || f == 6'b000111) ? rs[4:0] : sa;
    dbl = {rt, rt} >> n;
    case (f)
      6'b000000, 6'b000100: return {1'b0, rt << n};
      6'b000010, 6'b000110: return is_rot_op(f, r) ? {1'b0, dbl[31:0]} : {1'b0, rt >> n};
      6'b000011, 6'b000111: return {1'b0, 32'($signed(rt) >>> n)};
      default:              return {1'b1, 32'h0};
    endcase
  endfunction

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    m_ov  = 1'b0;
    m_rot = 1'b0;
    exp_q.delete();
  endtask

  // One clock: drive inputs, check at negedge, advance the model, cross the edge.
  task automatic step(input logic v, input logic [5:0] f, input logic r, input logic [4:0] sa,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd,
                      input logic ordy);
    logic        exp_ir;
    logic [32:0] ro;
    in_valid = v; funct = f; rot = r; shamt = sa;
    rs_val = rs; rt_val = rt; rd_in = rd; out_ready = ordy;
    @(negedge clk);
    exp_ir = !m_rot && (!m_ov || ordy);
    chk("in_ready", in_ready, exp_ir);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) begin
      if (exp_q.size() == 0) chk("out_unexpected", 1, 0);
      else chk("out_data", {illegal, rd_out, result}, exp_q[0]);
      if (ordy && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (m_rot) begin
      if (!m_ov || ordy) begin m_rot = 1'b0; m_ov = 1'b1; end
    end else if (v && exp_ir) begin
      ro = ref_op(f, r, sa, rs, rt);
      exp_q.push_back({ro[32], rd, ro[31:0]});
      if (is_rot_op(f, r)) begin m_rot = 1'b1; m_ov = m_ov && !ordy; end
      else m_ov = 1'b1;
    end else begin
      m_ov = m_ov && !ordy;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 6'd0, 1'b0, 5'd0, 32'd0, 32'd0, 5'd0, ordy);
  endtask

  logic [5:0] fl[8];

  initial begin
    fl = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h2A};
    m_ov = 1'b0; m_rot = 1'b0;
    repeat (2) @(posedge clk);
    do_reset();
    chk("reset_outs", {out_valid, illegal, rd_out, result}, 39'h0);
    chk("reset_in_ready", in_ready, 1'b1);

    // sra sign fill
    step(1'b1, 6'h03, 1'b0, 5'd4, 32'h0, 32'h80000000, 5'd3, 1'b1);
    chk("sra_valid", out_valid, 1'b1);
    chk("sra_result", {illegal, result}, {1'b0, 32'hF8000000});

    // sllv uses only rs[4:0]
    step(1'b1, 6'h04, 1'b0, 5'd0, 32'h25, 32'h1, 5'd17, 1'b1);
    chk("sllv_result", result, 32'h20);
    chk("sllv_rd", rd_out, 5'd17);

    // illegal funct
    step(1'b1, 6'h20, 1'b0, 5'd7, 32'h0, 32'hFFFF, 5'd9, 1'b1);
    chk("illegal_out", {out_valid, illegal, result}, {1'b1, 1'b1, 32'h0});
    idle(1'b1);

    // backpressure with a second op waiting
    step(1'b1, 6'h00, 1'b0, 5'd4, 32'h0, 32'h1, 5'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 6'h02, 1'b0, 5'd4, 32'h0, 32'h100, 5'd2, 1'b0);
      chk("bp_hold", {in_ready, result}, {1'b0, 32'h10});
    end
    step(1'b1, 6'h02, 1'b0, 5'd4, 32'h0, 32'h100, 5'd2, 1'b1);
    chk("bp_second", {out_valid, rd_out, result}, {1'b1, 5'd2, 32'h10});
    idle(1'b1);
    chk("bp_drained", out_valid, 1'b0);

    // rotate (or plain srl when the feature is off)
    step(1'b1, 6'h02, 1'b1, 5'd8, 32'h0, 32'h12345678, 5'd5, 1'b1);
    if (ROT_EN) begin
      chk("rot_busy", {in_ready, out_valid}, 2'b00);
      idle(1'b1);
      chk("rot_result", {out_valid, result}, {1'b1, 32'h78123456});
    end else begin
      chk("srl_result", {out_valid, result}, {1'b1, 32'h00123456});
    end
    idle(1'b1);

    // reset while a result or rotate is pending
    step(1'b1, 6'h06, 1'b1, 5'd0, 32'h4, 32'hA5A5A5A5, 5'd6, 1'b0);
    do_reset();
    chk("rst_mid_outs", {out_valid, illegal, rd_out, result}, 39'h0);
    step(1'b1, 6'h00, 1'b0, 5'd1, 32'h0, 32'h3, 5'd8, 1'b1);
    chk("post_rst_op", {out_valid, rd_out, result}, {1'b1, 5'd8, 32'h6});
    idle(1'b1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), fl[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
           5'($urandom), $urandom, $urandom, 5'($urandom), ($urandom_range(0, 3) != 0));
    end

    for (int i = 0; i < 20 && (exp_q.size() > 0 || m_ov); i++) idle(1'b1);
    chk("drain_timeout", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
